// File: rtl/icache_if.sv
// Fetch-side and arbiter-side signals of the instruction cache, bundled.
// The slave modport is the cache's view; master is the surrounding environment.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// A miss issues a single non-abortable memory read, fills the frame, then re-looks-up.
module icache #(
  parameter int NSETS = 16
) (
  input logic      CLK,
  input logic      nRST,
  icache_if.slave  bus
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [31:0]     miss_addr_q, miss_addr_d;
  logic            valid_q [NSETS];
  logic [TAGW-1:0] tag_q   [NSETS];
  logic [31:0]     data_q  [NSETS];

  logic [IDXW-1:0] req_idx, miss_idx;
  logic [TAGW-1:0] req_tag, miss_tag;
  logic            hit, fill;
  logic [1:0]      unused_offset;

  assign req_idx       = bus.imemaddr[IDXW+1:2];
  assign req_tag       = bus.imemaddr[31:IDXW+2];
  assign miss_idx      = miss_addr_q[IDXW+1:2];
  assign miss_tag      = miss_addr_q[31:IDXW+2];
  assign unused_offset = bus.imemaddr[1:0];

  always_comb begin
    hit         = (state_q == IDLE) && bus.imemREN && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);
    fill        = (state_q == FETCH) && !bus.iwait;
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    if (state_q == IDLE) begin
      if (bus.imemREN && !hit) begin
        miss_addr_d = {bus.imemaddr[31:2], 2'b00};
        state_d     = FETCH;
      end
    end else if (fill) begin
      // Fill completes regardless of what the datapath presents now.
      state_d = IDLE;
    end
  end

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[req_idx] : 32'h0;
  assign bus.iREN     = (state_q == FETCH);
  assign bus.iaddr    = (state_q == FETCH) ? miss_addr_q : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSETS; gi++) begin : g_frame
      logic wr_en;
      assign wr_en = fill && (int'(miss_idx) == gi);

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          valid_q[gi] <= 1'b0;
        end else if (wr_en) begin
          valid_q[gi] <= 1'b1;
        end
      end

      // Tag/data need no reset: they are only observed behind valid.
      always_ff @(posedge CLK) begin
        if (wr_en) begin
          tag_q[gi]  <= miss_tag;
          data_q[gi] <= bus.iload;
        end
      end
    end
  endgenerate
endmodule
